// File: rtl/rob_mp_pkg.sv
// Shared types for the reorder buffer: entry kinds, store widths, entry layout.
package rob_mp_pkg;

    localparam int ROB_SIZE = 32;
    localparam int ROB_IDW  = 5;

    typedef enum logic [2:0] {
        T_REG    = 3'd0,
        T_JALR   = 3'd1,
        T_SB     = 3'd2,
        T_SH     = 3'd3,
        T_SW     = 3'd4,
        T_BRANCH = 3'd5,
        T_EXIT   = 3'd6
    } rob_type_e;

    typedef enum logic [1:0] {
        ST_BYTE = 2'd0,
        ST_HALF = 2'd1,
        ST_WORD = 2'd2
    } st_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred_taken;
        logic [31:0] value;
        logic [31:0] aux;
    } rob_entry_t;

    function automatic st_type_e st_of(input rob_type_e t);
        case (t)
            T_SB:    st_of = ST_BYTE;
            T_SH:    st_of = ST_HALF;
            default: st_of = ST_WORD;
        endcase
    endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Folds the writeback channels into one write strobe per entry; on an id
// collision the highest-numbered channel wins.
module rob_wb_merge
    import rob_mp_pkg::*;
#(
    parameter int DEPTH    = ROB_SIZE,
    parameter int IDW      = ROB_IDW,
    parameter int WB_PORTS = 3
) (
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*IDW-1:0]    wb_id,
    input  logic [WB_PORTS*32-1:0]     wb_value,
    input  logic [WB_PORTS*32-1:0]     wb_aux,
    output logic [DEPTH-1:0]           we,
    output logic [DEPTH-1:0][31:0]     we_value,
    output logic [DEPTH-1:0][31:0]     we_aux
);

    always_comb begin
        we       = '0;
        we_value = '0;
        we_aux   = '0;
        for (int e = 0; e < DEPTH; e++) begin
            // Ascending scan: a later channel overwrites an earlier one.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_id[p*IDW +: IDW] == IDW'(e))) begin
                    we[e]       = 1'b1;
                    we_value[e] = wb_value[p*32 +: 32];
                    we_aux[e]   = wb_aux[p*32 +: 32];
                end
            end
        end
    end

endmodule

// File: rtl/rob_mp.sv
// Reorder buffer: in-order allocate, multi-channel writeback, single in-order
// retire of register writes, stores, branch outcomes, flushes and exit.
module rob_mp
    import rob_mp_pkg::*;
#(
    parameter int DEPTH    = ROB_SIZE,
    parameter int IDW      = ROB_IDW,
    parameter int WB_PORTS = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     alloc_valid,
    input  logic [2:0]               alloc_type,
    input  logic [4:0]               alloc_dest,
    input  logic [31:0]              alloc_pc,
    input  logic [31:0]              alloc_target,
    input  logic                     alloc_pred_taken,
    input  logic                     alloc_ready,
    input  logic [31:0]              alloc_value,
    output logic [IDW-1:0]           alloc_id,
    output logic                     full,
    output logic                     empty,
    output logic [IDW:0]             count,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*IDW-1:0]  wb_id,
    input  logic [WB_PORTS*32-1:0]   wb_value,
    input  logic [WB_PORTS*32-1:0]   wb_aux,
    output logic                     rf_valid,
    output logic [4:0]               rf_rd,
    output logic [31:0]              rf_value,
    output logic [IDW-1:0]           rf_rob_id,
    input  logic                     mem_busy,
    output logic                     st_valid,
    output logic [1:0]               st_type,
    output logic [31:0]              st_addr,
    output logic [31:0]              st_data,
    output logic                     pred_valid,
    output logic [31:0]              pred_pc,
    output logic                     pred_taken,
    output logic                     flush,
    output logic [31:0]              flush_addr,
    output logic                     halt
);

    rob_entry_t            ent [DEPTH];
    logic [IDW-1:0]        head, tail;
    logic [DEPTH-1:0]      we;
    logic [DEPTH-1:0][31:0] we_value, we_aux;
    rob_entry_t            h;
    logic                  alloc_do, commit_do;
    logic                  rf_fire, st_fire, pred_fire, flush_fire, halt_set;
    logic [31:0]           rf_val, flush_tgt;

    rob_wb_merge #(.DEPTH(DEPTH), .IDW(IDW), .WB_PORTS(WB_PORTS)) u_merge (
        .wb_valid (wb_valid),
        .wb_id    (wb_id),
        .wb_value (wb_value),
        .wb_aux   (wb_aux),
        .we       (we),
        .we_value (we_value),
        .we_aux   (we_aux)
    );

    assign full     = (count == (IDW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign alloc_id = tail;
    assign alloc_do = alloc_valid && !full;
    assign h        = ent[head];

    // Retire decision looks only at registered head state.
    always_comb begin
        commit_do  = 1'b0;
        rf_fire    = 1'b0;
        st_fire    = 1'b0;
        pred_fire  = 1'b0;
        flush_fire = 1'b0;
        halt_set   = 1'b0;
        rf_val     = h.value;
        flush_tgt  = h.value;
        if (h.busy && h.ready && !halt) begin
            case (h.typ)
                T_REG: begin
                    commit_do = 1'b1;
                    rf_fire   = 1'b1;
                end
                T_JALR: begin
                    commit_do  = 1'b1;
                    rf_fire    = 1'b1;
                    rf_val     = h.pc + 32'd4;
                    flush_fire = (h.value != h.target);
                end
                T_SB, T_SH, T_SW: begin
                    commit_do = !mem_busy;
                    st_fire   = !mem_busy;
                end
                T_BRANCH: begin
                    commit_do  = 1'b1;
                    pred_fire  = 1'b1;
                    flush_fire = (h.value[0] != h.pred_taken);
                    flush_tgt  = h.value[0] ? h.target : h.pc + 32'd4;
                end
                T_EXIT: begin
                    commit_do = 1'b1;
                    halt_set  = 1'b1;
                end
                default: commit_do = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rf_valid   <= 1'b0;
            rf_rd      <= '0;
            rf_value   <= '0;
            rf_rob_id  <= '0;
            st_valid   <= 1'b0;
            st_type    <= '0;
            st_addr    <= '0;
            st_data    <= '0;
            pred_valid <= 1'b0;
            pred_pc    <= '0;
            pred_taken <= 1'b0;
            flush      <= 1'b0;
            flush_addr <= '0;
            halt       <= 1'b0;
            for (int e = 0; e < DEPTH; e++) ent[e] <= '0;
        end else if (rdy_in) begin
            rf_valid   <= rf_fire;
            st_valid   <= st_fire;
            pred_valid <= pred_fire;
            flush      <= flush_fire;
            halt       <= halt | halt_set;
            if (rf_fire) begin
                rf_rd     <= h.dest;
                rf_value  <= rf_val;
                rf_rob_id <= head;
            end
            if (st_fire) begin
                st_type <= st_of(h.typ);
                st_addr <= h.aux;
                st_data <= h.value;
            end
            if (pred_fire) begin
                pred_pc    <= h.pc;
                pred_taken <= h.value[0];
            end
            if (flush_fire) flush_addr <= flush_tgt;

            if (flush_fire) begin
                // Younger work is squashed, including this cycle's alloc/writeback.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    ent[e].busy  <= 1'b0;
                    ent[e].ready <= 1'b0;
                end
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (we[e] && ent[e].busy) begin
                        ent[e].value <= we_value[e];
                        ent[e].aux   <= we_aux[e];
                        ent[e].ready <= 1'b1;
                    end
                end
                if (commit_do) begin
                    ent[head].busy <= 1'b0;
                    head           <= head + IDW'(1);
                end
                if (alloc_do) begin
                    ent[tail] <= '{busy: 1'b1, ready: alloc_ready,
                                   typ: rob_type_e'(alloc_type), dest: alloc_dest,
                                   pc: alloc_pc, target: alloc_target,
                                   pred_taken: alloc_pred_taken,
                                   value: alloc_value, aux: 32'd0};
                    tail <= tail + IDW'(1);
                end
                count <= count + (IDW+1)'(alloc_do) - (IDW+1)'(commit_do);
            end
        end
    end

endmodule
